// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED Hamming(16,11) decoder.
// Contents: FSM state enum, 2-bit status flag encodings, codeword geometry
// (widths and the Hamming positions that carry data bits).
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_DECODE,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam logic [1:0] F_CLEAN  = 2'b00;
  localparam logic [1:0] F_SINGLE = 2'b01;
  localparam logic [1:0] F_DOUBLE = 2'b10;

  localparam int CW_BITS   = 16;
  localparam int DATA_BITS = 11;

  // Hamming position of data bit i: every non-power-of-two position 3..15.
  localparam int DATA_POS [DATA_BITS] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED Hamming(16,11) check/correct stage.
// Ports: cw (16-bit codeword) in; data (11-bit corrected data), flag
// (CLEAN/SINGLE/DOUBLE) and syndrome (failing Hamming position) out.
module hamming_secded_core
  import hamming_pkg::*;
(
  input  logic [CW_BITS-1:0]   cw,
  output logic [DATA_BITS-1:0] data,
  output logic [1:0]           flag,
  output logic [3:0]           syndrome
);

  logic                 parity;
  logic                 correct;
  logic [DATA_BITS-1:0] data_raw;
  logic [DATA_BITS-1:0] flip;

  always_comb begin
    syndrome[3] = ^cw[15:8];
    syndrome[2] = ^{cw[15:12], cw[7:4]};
    syndrome[1] = ^{cw[15:14], cw[11:10], cw[7:6], cw[3:2]};
    syndrome[0] = ^{cw[15], cw[13], cw[11], cw[9], cw[7], cw[5], cw[3], cw[1]};
    parity      = ^cw;

    flag    = F_CLEAN;
    correct = 1'b0;
    if (parity) begin
      // Odd overall parity: exactly one bit flipped. A zero syndrome means
      // p0 itself flipped, so no data bit needs repair.
      flag    = F_SINGLE;
      correct = 1'b1;
    end else if (syndrome != 4'd0) begin
      flag = F_DOUBLE;
    end

    // Only a syndrome pointing at a data position can change the data;
    // syndromes pointing at parity positions leave flip all-zero.
    for (int i = 0; i < DATA_BITS; i++) begin
      data_raw[i] = cw[DATA_POS[i]];
      flip[i]     = (int'(syndrome) == DATA_POS[i]);
    end

    data = correct ? (data_raw ^ flip) : data_raw;
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-driven SECDED decoder: reads N_WORDS 16-bit codewords starting at
// SRC_BASE, writes {flag, 000, d[10:8]} / d[7:0] pairs starting at DST_BASE.
// Ports: clk, reset (async active-low), Init (sync hold/restart), memory read
// (raddr/rdata) and write (waddr/wdata/we) ports, done, error counters.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int W        = 8,
  parameter int A        = 8,
  parameter int N_WORDS  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Init,
  output logic [A-1:0] raddr,
  input  logic [W-1:0] rdata,
  output logic [A-1:0] waddr,
  output logic [W-1:0] wdata,
  output logic         we,
  output logic         done,
  output logic [3:0]   single_cnt,
  output logic [3:0]   double_cnt
);

  localparam int KW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [W-1:0]         lo_q, hi_q;
  logic [DATA_BITS-1:0] data_q, dec_data;
  logic [1:0]           flag_q, dec_flag;
  logic [3:0]           syn_unused;
  logic                 last_word;
  logic [A-1:0]         word_off;

  hamming_secded_core u_core (
    .cw       ({hi_q, lo_q}),
    .data     (dec_data),
    .flag     (dec_flag),
    .syndrome (syn_unused)
  );

  assign last_word = (k_q == KW'(N_WORDS - 1));
  assign word_off  = A'(k_q) << 1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_RD_LO;
      ST_RD_LO:  state_d = ST_RD_HI;
      ST_RD_HI:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_WR_LO;
      ST_WR_LO:  state_d = ST_WR_HI;
      ST_WR_HI:  state_d = last_word ? ST_DONE : ST_RD_LO;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
    if (Init) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      data_q     <= '0;
      flag_q     <= F_CLEAN;
      single_cnt <= 4'd0;
      double_cnt <= 4'd0;
      done       <= 1'b0;
    end else if (Init) begin
      k_q        <= '0;
      single_cnt <= 4'd0;
      double_cnt <= 4'd0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        ST_RD_LO: lo_q <= rdata;
        ST_RD_HI: hi_q <= rdata;
        ST_DECODE: begin
          data_q <= dec_data;
          flag_q <= dec_flag;
          if (dec_flag == F_SINGLE && single_cnt != 4'hF) begin
            single_cnt <= single_cnt + 4'd1;
          end
          if (dec_flag == F_DOUBLE && double_cnt != 4'hF) begin
            double_cnt <= double_cnt + 4'd1;
          end
        end
        ST_WR_HI: begin
          if (last_word) begin
            done <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port is decoded from the state register, so an asynchronous
  // reset kills an in-flight write in the same cycle.
  always_comb begin
    raddr = '0;
    waddr = '0;
    wdata = '0;
    we    = 1'b0;
    case (state_q)
      ST_RD_LO: raddr = A'(SRC_BASE) + word_off;
      ST_RD_HI: raddr = A'(SRC_BASE) + word_off + A'(1);
      ST_WR_LO: begin
        we    = 1'b1;
        waddr = A'(DST_BASE) + word_off;
        wdata = W'(data_q[7:0]);
      end
      ST_WR_HI: begin
        we    = 1'b1;
        waddr = A'(DST_BASE) + word_off + A'(1);
        wdata = W'({flag_q, 3'b000, data_q[10:8]});
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine: behavioural memory, a
// position-arithmetic SECDED reference model, and scenario tasks.
module tb_hamming_dec_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       Init;
  logic [7:0] raddr, waddr, wdata, rdata;
  logic       we, done;
  logic [3:0] single_cnt, double_cnt;

  logic [7:0]  mem [256];
  logic [15:0] cw_tab [15];
  int tests = 0;
  int fails = 0;
  int bad_wr = 0;

  hamming_dec_engine dut (
    .clk        (clk),
    .reset      (reset),
    .Init       (Init),
    .raddr      (raddr),
    .rdata      (rdata),
    .waddr      (waddr),
    .wdata      (wdata),
    .we         (we),
    .done       (done),
    .single_cnt (single_cnt),
    .double_cnt (double_cnt)
  );

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  always @(posedge clk) begin
    if (we) begin
      if (waddr >= 8'd30) bad_wr++;
      mem[waddr] = wdata;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    s = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p < 16; p++) if (c[p]) s ^= p;
    for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Returns {high byte, low byte} expected in memory; f is the status code.
  function automatic logic [15:0] ref_dec(input logic [15:0] cw_in, output int f);
    logic [15:0] c;
    logic [10:0] d;
    int s;
    int j;
    c = cw_in;
    s = 0;
    for (int p = 1; p < 16; p++) if (c[p]) s ^= p;
    if ($countones(c) % 2 == 1) begin
      f = 1;
      if (s != 0) c[s] = ~c[s];
    end else if (s != 0) begin
      f = 2;
    end else begin
      f = 0;
    end
    j = 0;
    d = '0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return {f[1:0], 3'b000, d[10:8], d[7:0]};
  endfunction

  function automatic int mem_word_errors();
    int e;
    int f;
    logic [15:0] x;
    e = 0;
    for (int k = 0; k < 15; k++) begin
      x = ref_dec(cw_tab[k], f);
      if (mem[2*k] !== x[7:0] || mem[2*k+1] !== x[15:8]) e++;
    end
    return e;
  endfunction

  function automatic int ref_count(input int which);
    int n;
    int f;
    logic [15:0] x;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      x = ref_dec(cw_tab[k], f);
      if (f == which && n < 15) n++;
    end
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'hAA;
    for (int k = 0; k < 15; k++) begin
      mem[30 + 2*k]     = cw_tab[k][7:0];
      mem[30 + 2*k + 1] = cw_tab[k][15:8];
    end
    bad_wr = 0;
  endtask

  task automatic rand_words(input int mode);
    int b1;
    int b2;
    for (int k = 0; k < 15; k++) begin
      cw_tab[k] = (k % 4 == 0) ? 16'h0000 : enc(11'($urandom));
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (mode == 1 || (mode == 0 && k % 3 == 1)) cw_tab[k][b1] = ~cw_tab[k][b1];
      if (mode == 0 && k % 3 == 2) begin
        cw_tab[k][b1] = ~cw_tab[k][b1];
        cw_tab[k][b2] = ~cw_tab[k][b2];
      end
    end
  endtask

  // Drops Init at a negedge (engine idle) and clocks ncyc cycles, checking
  // the cycle schedule of we/raddr/waddr and the done edge at cycle 76.
  task automatic run_engine(input int ncyc, output int sched_err, output int first_bad);
    int ph;
    int k;
    logic [7:0] er, ew;
    logic ewe, edone;
    sched_err = 0;
    first_bad = 0;
    Init = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      ph = (n - 1) % 5;
      k  = (n - 1) / 5;
      er = 8'd0; ew = 8'd0; ewe = 1'b0;
      if (n <= 75) begin
        if (ph == 0) er = 8'(30 + 2*k);
        if (ph == 1) er = 8'(31 + 2*k);
        if (ph == 3) ew = 8'(2*k);
        if (ph == 4) ew = 8'(2*k + 1);
        ewe = (ph >= 3);
      end
      edone = (n >= 76);
      if (we !== ewe || raddr !== er || waddr !== ew || done !== edone) begin
        if (sched_err == 0) first_bad = n;
        sched_err++;
      end
    end
  endtask

  task automatic finish_run();
    Init = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    Init  = 1'b1;
    #1;
    tests++;
    if ({we, done, raddr, waddr, wdata, single_cnt, double_cnt} !== 35'd0) begin
      fails++;
      $display("FAIL reset_state: got we=%b done=%b raddr=%h waddr=%h wdata=%h sc=%0d dc=%0d, want all 0",
               we, done, raddr, waddr, wdata, single_cnt, double_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (we !== 1'b0 || raddr !== 8'd0) begin
      fails++;
      $display("FAIL init_hold: we=%b raddr=%h, want 0/00", we, raddr);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vec [5];
    logic [7:0]  lo_e [5];
    logic [7:0]  hi_e [5];
    int sc_e [5];
    int dc_e [5];
    int se, fb;
    vec  = '{16'hFFFF, 16'hFFDF, 16'hFFFE, 16'hFFD7, 16'h0000};
    lo_e = '{8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00};
    hi_e = '{8'h07, 8'h47, 8'h47, 8'h87, 8'h00};
    sc_e = '{0, 1, 1, 0, 0};
    dc_e = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 15; k++) cw_tab[k] = 16'h0000;
      cw_tab[0] = vec[i];
      load_mem();
      run_engine(76, se, fb);
      tests++;
      if (mem[0] !== lo_e[i] || mem[1] !== hi_e[i]) begin
        fails++;
        $display("FAIL directed_%0d cw=%h: mem0/1=%h/%h want %h/%h",
                 i, vec[i], mem[0], mem[1], lo_e[i], hi_e[i]);
      end
      tests++;
      if (single_cnt !== 4'(sc_e[i]) || double_cnt !== 4'(dc_e[i])) begin
        fails++;
        $display("FAIL directed_cnt_%0d: sc=%0d dc=%0d want %0d/%0d",
                 i, single_cnt, double_cnt, sc_e[i], dc_e[i]);
      end
      finish_run();
    end
  endtask

  task automatic test_full_random(input int mode, input string tag);
    int se, fb, we_err;
    rand_words(mode);
    load_mem();
    run_engine(80, se, fb);
    tests++;
    if (se !== 0) begin
      fails++;
      $display("FAIL %s_schedule: %0d bad cycles, first at cycle %0d, want 0", tag, se, fb);
    end
    we_err = mem_word_errors();
    tests++;
    if (we_err !== 0) begin
      fails++;
      $display("FAIL %s_memory: %0d wrong words, want 0", tag, we_err);
    end
    tests++;
    if (single_cnt !== 4'(ref_count(1)) || double_cnt !== 4'(ref_count(2))) begin
      fails++;
      $display("FAIL %s_counts: sc=%0d dc=%0d want %0d/%0d",
               tag, single_cnt, double_cnt, ref_count(1), ref_count(2));
    end
    tests++;
    if (bad_wr !== 0) begin
      fails++;
      $display("FAIL %s_write_range: %0d writes above 29, want 0", tag, bad_wr);
    end
    finish_run();
  endtask

  task automatic test_reset_abort();
    int se, fb;
    rand_words(0);
    load_mem();
    run_engine(38, se, fb);
    @(posedge clk);
    #1;
    tests++;
    if (we !== 1'b1 || waddr !== 8'd14) begin
      fails++;
      $display("FAIL abort_precond: cycle 39 we=%b waddr=%h want 1/0e", we, waddr);
    end
    Init  = 1'b1;
    reset = 1'b0;
    #1;
    tests++;
    if ({we, done, raddr, waddr, wdata, single_cnt, double_cnt} !== 35'd0) begin
      fails++;
      $display("FAIL abort_reset: we=%b done=%b raddr=%h waddr=%h wdata=%h sc=%0d dc=%0d want all 0",
               we, done, raddr, waddr, wdata, single_cnt, double_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init_restart();
    int se, fb, werr;
    rand_words(0);
    load_mem();
    run_engine(42, se, fb);
    Init = 1'b1;
    @(negedge clk);
    tests++;
    if (we !== 1'b0 || single_cnt !== 4'd0 || double_cnt !== 4'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL init_abort: we=%b sc=%0d dc=%0d done=%b want 0", we, single_cnt, double_cnt, done);
    end
    for (int a = 0; a < 30; a++) mem[a] = 8'hAA;
    run_engine(76, se, fb);
    tests++;
    if (se !== 0) begin
      fails++;
      $display("FAIL restart_schedule: %0d bad cycles, first at %0d, want 0", se, fb);
    end
    werr = mem_word_errors();
    tests++;
    if (werr !== 0 || single_cnt !== 4'(ref_count(1)) || double_cnt !== 4'(ref_count(2))) begin
      fails++;
      $display("FAIL restart_result: %0d wrong words sc=%0d dc=%0d want 0 %0d/%0d",
               werr, single_cnt, double_cnt, ref_count(1), ref_count(2));
    end
    finish_run();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full_random(0, "mixed_a");
    test_full_random(0, "mixed_b");
    test_full_random(1, "all_single");
    test_full_random(2, "all_clean");
    test_reset_abort();
    test_init_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
